// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg: shared state encoding and default operand width for the sequential multiplier
package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

endpackage

// File: rtl/adder_nbit.sv
// adder_nbit: N-bit ripple-carry adder chained from full_adder cells
module adder_nbit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         ci_i,
    output logic [N-1:0] s_o,
    output logic         co_o
);

    logic [N:0] c;

    assign c[0] = ci_i;
    assign co_o = c[N];

    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder u_fa (
            .a_i  (a_i[i]),
            .b_i  (b_i[i]),
            .ci_i (c[i]),
            .s_o  (s_o[i]),
            .co_o (c[i+1])
        );
    end

endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, unsigned or sign-magnitude signed, with ready/valid handshakes
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] M
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               neg_q, neg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0]   a_mag, b_mag, addend;
    logic [WIDTH:0]     sum;
    logic               unused_co;

    // Signed operands are reduced to magnitudes; the most-negative value maps to 2^(WIDTH-1), still fitting unsigned.
    assign a_mag  = (signed_mode && A[WIDTH-1]) ? -A : A;
    assign b_mag  = (signed_mode && B[WIDTH-1]) ? -B : B;
    assign addend = b_q[cnt_q] ? a_q : {WIDTH{1'b0}};

    adder_nbit #(
        .N (WIDTH + 1)
    ) u_add (
        .a_i  ({1'b0, acc_q[2*WIDTH-1:WIDTH]}),
        .b_i  ({1'b0, addend}),
        .ci_i (1'b0),
        .s_o  (sum),
        .co_o (unused_co)
    );

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign M         = m_q;

    // Next-state and datapath: accept in IDLE, one shift-add per CALC edge, sign fix in FIX, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_mag;
                    b_d     = b_mag;
                    neg_d   = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = {sum, acc_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : CALC;
            end
            FIX: begin
                m_d     = neg_q ? ~acc_q + 1'b1 : acc_q;
                state_d = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight and clears the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and exhaustive checks of seq_multiplier at WIDTH=4
module tb_seq_multiplier;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_ready;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic       signed_mode = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] M;

    int compared = 0;
    int mismatched = 0;

    seq_multiplier #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .M           (M)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sx4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    // Full transaction: accept, latency check, product check, handshake back to IDLE.
    task automatic mul(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic s, input logic [7:0] exp);
        A = a;
        B = b;
        signed_mode = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = ~a;
        B = ~b;
        signed_mode = ~s;
        chk({tag, "_busy"}, in_ready, 0);
        repeat (4) tick();
        chk({tag, "_nv_fix"}, out_valid, 0);
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_M"}, M, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drop"}, out_valid, 0);
        chk({tag, "_idle"}, in_ready, 1);
    endtask

    initial begin
        logic [3:0] ra, rb;
        logic [7:0] held;
        int a, b, e;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_M", M, 0);

        mul("u15x15", 4'hF, 4'hF, 1'b0, 8'hE1);
        chk("retain_M", M, 8'hE1);
        mul("s8x8", 4'h8, 4'h8, 1'b1, 8'h40);
        mul("sDx5", 4'hD, 4'h5, 1'b1, 8'hF1);
        mul("s0x9", 4'h0, 4'h9, 1'b1, 8'h00);
        mul("s7x8", 4'h7, 4'h8, 1'b1, 8'hC8);
        mul("uFx8", 4'hF, 4'h8, 1'b0, 8'h78);

        // Back-pressure: hold DONE for 10 cycles.
        A = 4'h6; B = 4'h9; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("bp_valid", out_valid, 1);
        chk("bp_M", M, 8'h36);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_M", M, 8'h36);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);

        // start during CALC is ignored; start on the DONE handshake edge is ignored too.
        A = 4'h7; B = 4'h3; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        A = 4'h2; B = 4'h2;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("ign_valid", out_valid, 1);
        chk("ign_M", M, 8'h15);
        A = 4'h1; B = 4'h1; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("ign_hs_ready", in_ready, 1);
        tick();
        chk("ign_hs_noaccept", in_ready, 1);
        chk("ign_hs_M", M, 8'h15);

        // Reset on the second CALC edge aborts with no valid pulse.
        A = 4'h5; B = 4'h5; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", in_ready, 1);
        chk("abort_valid", out_valid, 0);
        chk("abort_M", M, 0);
        repeat (6) tick();
        chk("abort_no_pulse", out_valid, 0);
        mul("post_abort", 4'h3, 4'h4, 1'b0, 8'h0C);

        // Sweep all operand pairs in both modes, visited in a randomised order.
        ra = 4'($urandom_range(0, 15));
        rb = 4'($urandom_range(0, 15));
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int s = 0; s < 2; s++) begin
                    a = int'(4'(i) ^ ra);
                    b = int'(4'(j) ^ rb);
                    e = (s == 1) ? ((sx4(a) * sx4(b)) & 255) : a * b;
                    held = 8'(e);
                    mul("sweep", 4'(a), 4'(b), s[0], held);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
